// File: rtl/ahb_bram_ctrl_pkg.sv
// ahb_bram_ctrl_pkg: AHB codes and bram controller state encodings shared with ahb_bridge.
// ERR states exist only when BRAM_CTRL_ERR_EN is defined.
package ahb_bram_ctrl_pkg;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WRITE       = 3'd1;
    localparam logic [2:0] S_READ        = 3'd2;
    localparam logic [2:0] S_RD_PEND     = 3'd3;
`ifdef BRAM_CTRL_ERR_EN
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] S_ERR1        = 3'd4;
    localparam logic [2:0] S_ERR2        = 3'd5;
`endif
endpackage

// File: rtl/ahb_lane_strobe.sv
// ahb_lane_strobe: byte-lane strobe and alignment decode for a 32-bit AHB slave.
// Oversized hsize decodes as a word so non-checking slaves degrade gracefully.
module ahb_lane_strobe
    import ahb_bram_ctrl_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strobe,
    output logic       misalign,
    output logic       bad_size
);
    assign strobe = (hsize == HSIZE_BYTE) ? (4'b0001 << addr_lo) :
                    (hsize == HSIZE_HALF) ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign misalign = ((hsize == HSIZE_HALF) & addr_lo[0]) | ((hsize == HSIZE_WORD) & (addr_lo != 2'b00));
    assign bad_size = hsize > HSIZE_WORD;
endmodule

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave sequencing BRAM port B; address-phase reads, write-wins collisions.
// BRAM_CTRL_ERR_EN enables ERROR responses for oversized or misaligned transfers.
module ahb_bram_ctrl
    import ahb_bram_ctrl_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready_i,
    output logic              hready_o,
    output logic              hresp_o,
    output logic [DATA_W-1:0] hrdata_o,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [MEM_AW-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);
    logic [2:0]        state, nxt;
    logic [MEM_AW-1:0] addr_q;
    logic [3:0]        strb_q, strobe;
    logic              misalign, bad_size, accept, illegal, rd_now, unused_ok;

    ahb_lane_strobe u_strobe (
        .hsize    (hsize),
        .addr_lo  (haddr[1:0]),
        .strobe   (strobe),
        .misalign (misalign),
        .bad_size (bad_size)
    );

    assign accept = hsel & hready_i & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
`ifdef BRAM_CTRL_ERR_EN
    assign illegal   = misalign | bad_size;
    assign unused_ok = ^haddr[31:MEM_AW+2];
    assign hready_o  = (state != S_RD_PEND) & (state != S_ERR1);
    assign hresp_o   = ((state == S_ERR1) | (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign illegal   = 1'b0;
    assign unused_ok = ^{haddr[31:MEM_AW+2], misalign, bad_size};
    assign hready_o  = state != S_RD_PEND;
    assign hresp_o   = HRESP_OKAY;
`endif

    // A read meeting a write data phase loses the port and is replayed from RD_PEND
    assign rd_now = hreset_n & accept & ~hwrite & ~illegal & (state != S_WRITE);

    always_comb begin
        nxt = S_IDLE;
        if (state == S_RD_PEND)
            nxt = S_READ;
`ifdef BRAM_CTRL_ERR_EN
        else if (state == S_ERR1)
            nxt = S_ERR2;
        else if (accept)
            nxt = illegal ? S_ERR1 : hwrite ? S_WRITE : (state == S_WRITE) ? S_RD_PEND : S_READ;
`else
        else if (accept)
            nxt = hwrite ? S_WRITE : (state == S_WRITE) ? S_RD_PEND : S_READ;
`endif
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state  <= S_IDLE;
            addr_q <= '0;
            strb_q <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                addr_q <= haddr[MEM_AW+1:2];
                strb_q <= strobe;
            end
        end
    end

    assign bram_en   = (state == S_WRITE) | (state == S_RD_PEND) | rd_now;
    assign bram_we   = (state == S_WRITE) ? strb_q : 4'b0000;
    assign bram_addr = ((state == S_WRITE) | (state == S_RD_PEND)) ? addr_q : haddr[MEM_AW+1:2];
    assign bram_din  = hwdata;
    assign hrdata_o  = (state == S_READ) ? bram_dout : '0;
endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb_ahb_bram_ctrl: directed checks of ahb_bram_ctrl against a behavioural BRAM.
// Build with or without BRAM_CTRL_ERR_EN; the illegal-transfer case follows the macro.
module tb_ahb_bram_ctrl;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

    logic        hclk = 1'b0, hreset_n, hsel, hwrite, hready_i, hready_o, hresp_o, bram_en;
    logic [31:0] haddr, hwdata, hrdata_o, bram_din, bram_dout;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] mem [1024];
    int          total = 0, bad = 0;

    ahb_bram_ctrl dut (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_i(hready_i),
        .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always #5 hclk = ~hclk;
    assign hready_i = hready_o;

    always @(posedge hclk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ap(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic step;
        @(posedge hclk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        ap(1'b1, T_NSEQ, 1'b1, a, sz);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        hwdata = d;
        step;
    endtask

    initial begin
        hreset_n = 1'b0;
        hwdata = 32'h0;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | i;
        #3;
        chk("rst_hready", hready_o, 1);
        chk("rst_hresp", hresp_o, 0);
        chk("rst_hrdata", hrdata_o, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_we", bram_we, 0);
        step; step;
        hreset_n = 1'b1;
        #1;
        // word write then zero-wait read of another word
        ap(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2);
        #1 chk("t1_wap_en", bram_en, 0);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        hwdata = 32'hDEADBEEF;
        #1;
        chk("t1_we", bram_we, 4'b1111);
        chk("t1_addr", bram_addr, 4);
        chk("t1_din", bram_din, 32'hDEADBEEF);
        chk("t1_w_rdy", hready_o, 1);
        step;
        ap(1'b1, T_NSEQ, 1'b0, 32'h20, 3'd2);
        #1;
        chk("t1_rap_en", bram_en, 1);
        chk("t1_rap_addr", bram_addr, 8);
        chk("t1_rap_we", bram_we, 0);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        #1;
        chk("t1_rd_rdy", hready_o, 1);
        chk("t1_rdata", hrdata_o, 32'hC0DE0008);
        chk("t1_mem", mem[4], 32'hDEADBEEF);
        step;
        // byte write into the top lane of a word
        wr(32'h0, 3'd2, 32'h11223344);
        ap(1'b1, T_NSEQ, 1'b1, 32'h3, 3'd0);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        hwdata = 32'hAA000000;
        #1;
        chk("t2_we", bram_we, 4'b1000);
        chk("t2_addr", bram_addr, 0);
        step;
        ap(1'b1, T_NSEQ, 1'b0, 32'h0, 3'd2);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        #1 chk("t2_rdata", hrdata_o, 32'hAA223344);
        step;
        // back-to-back write then read of the same word
        ap(1'b1, T_NSEQ, 1'b1, 32'h20, 3'd2);
        step;
        ap(1'b1, T_NSEQ, 1'b0, 32'h20, 3'd2);
        hwdata = 32'h55;
        #1;
        chk("t3_we", bram_we, 4'b1111);
        chk("t3_addr", bram_addr, 8);
        chk("t3_w_rdy", hready_o, 1);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        #1;
        chk("t3_pend_rdy", hready_o, 0);
        chk("t3_pend_en", bram_en, 1);
        chk("t3_pend_we", bram_we, 0);
        chk("t3_pend_addr", bram_addr, 8);
        chk("t3_pend_rdata", hrdata_o, 0);
        step;
        #1;
        chk("t3_rdy", hready_o, 1);
        chk("t3_rdata", hrdata_o, 32'h55);
        step;
        // misaligned halfword read
        ap(1'b1, T_NSEQ, 1'b0, 32'h1, 3'd1);
`ifdef BRAM_CTRL_ERR_EN
        #1 chk("t4_ap_en", bram_en, 0);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        #1;
        chk("t4_e1_rdy", hready_o, 0);
        chk("t4_e1_resp", hresp_o, 1);
        chk("t4_e1_en", bram_en, 0);
        step;
        #1;
        chk("t4_e2_rdy", hready_o, 1);
        chk("t4_e2_resp", hresp_o, 1);
        chk("t4_e2_en", bram_en, 0);
        step;
        #1 chk("t4_after_resp", hresp_o, 0);
`else
        #1;
        chk("t4_ap_en", bram_en, 1);
        chk("t4_ap_addr", bram_addr, 0);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        #1;
        chk("t4_rdy", hready_o, 1);
        chk("t4_resp", hresp_o, 0);
        chk("t4_rdata", hrdata_o, 32'hAA223344);
`endif
        step;
        // reset asserted in the middle of a write data phase
        ap(1'b1, T_NSEQ, 1'b1, 32'h40, 3'd2);
        step;
        ap(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0);
        hwdata = 32'h12345678;
        #1 chk("t5_we_pre", bram_we, 4'b1111);
        hreset_n = 1'b0;
        #1;
        chk("t5_we", bram_we, 0);
        chk("t5_en", bram_en, 0);
        chk("t5_rdy", hready_o, 1);
        chk("t5_resp", hresp_o, 0);
        chk("t5_rdata", hrdata_o, 0);
        step;
        chk("t5_mem", mem[16], 32'hC0DE0010);
        hreset_n = 1'b1;
        #1;
        // selected but IDLE/BUSY transfers
        for (int i = 0; i < 4; i++) begin
            ap(1'b1, i[0] ? T_BUSY : T_IDLE, 1'b1, 32'h10, 3'd2);
            #1;
            chk("t6_en", bram_en, 0);
            chk("t6_we", bram_we, 0);
            chk("t6_rdy", hready_o, 1);
            chk("t6_resp", hresp_o, 0);
            step;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
